// File: rtl/ubolo_pkg.sv
// ---------------------------------------------------------------------------
// ubolo_pkg
// Shared definitions for the bolometer mux-matrix scan logic:
//   - scan FSM state encoding
//   - debug struct exposing the scan FSM state and the latched mode bit
//   - clog2 helper used to size counters from their wrap value
// ---------------------------------------------------------------------------
package ubolo_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;

    typedef struct packed {
        logic [1:0] state;  // current scan FSM state
        logic       cont;   // latched continuous-mode flag
    } scan_dbg_t;

    // Number of bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_wrap.sv
// ---------------------------------------------------------------------------
// counter_wrap
// Modulo-Max up-counter with a wrap flag, used for the row and column
// address of the scan.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset, clears the count
//   clr_i    synchronous clear, priority over en_i
//   en_i     advance the count by one (wrapping Max-1 -> 0)
//   count_o  current count, zero-extended to Width bits
//   wrap_o   en_i && count == Max-1 (the count wraps on this edge)
// ---------------------------------------------------------------------------
module counter_wrap
    import ubolo_pkg::*;
#(
    parameter int Width = 5,
    parameter int Max   = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o,
    output logic             wrap_o
);

    // The register is only as wide as Max needs, so bits of count_o above
    // that are structurally zero.
    localparam int CW = (clog2(Max) < 1) ? 1 : clog2(Max);

    logic [CW-1:0] r_count;
    logic          w_at_max;

    assign w_at_max = (r_count == CW'(Max - 1));
    assign wrap_o   = en_i && w_at_max;
    assign count_o  = Width'(r_count);

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (en_i) begin
            r_count <= w_at_max ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/matrix_scan_ctrl.sv
// ---------------------------------------------------------------------------
// matrix_scan_ctrl
// Row/column scan controller for the bolometer multiplexer matrix. Steps a
// Rows x Cols pixel address (column inner loop), holds each pixel for
// dwell_q settle cycles, strobes sample_o once per pixel and pulses
// frame_done_o with the last pixel's strobe. Single or continuous frames.
// Ports:
//   clk_i         system clock
//   rst_i         synchronous active-high reset
//   start_i       begin a frame (only honoured in IDLE)
//   cont_i        continuous mode, sampled at start and at each frame end
//   abort_i       stop the scan, return to IDLE at address (0,0)
//   dwell_i       settle cycles per pixel (0 is treated as 1), latched at start
//   row_o/col_o   current pixel address
//   sample_o      one-cycle strobe: pixel (row_o,col_o) is settled
//   frame_done_o  one-cycle pulse with the last pixel's sample_o
//   busy_o        high whenever the scan is not idle
//   dbg_o         FSM state and latched continuous flag
// All outputs except dbg_o are registered, one cycle behind the FSM state.
// ---------------------------------------------------------------------------
module matrix_scan_ctrl
    import ubolo_pkg::*;
#(
    parameter int Rows       = 2,
    parameter int Cols       = 2,
    parameter int Width      = 5,
    parameter int DwellWidth = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  cont_i,
    input  logic                  abort_i,
    input  logic [DwellWidth-1:0] dwell_i,
    output logic [Width-1:0]      row_o,
    output logic [Width-1:0]      col_o,
    output logic                  sample_o,
    output logic                  frame_done_o,
    output logic                  busy_o,
    output scan_dbg_t             dbg_o
);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DwellWidth-1:0] r_dwell_q;
    logic [DwellWidth-1:0] r_dwell_cnt;
    logic                  r_cont_q;
    logic                  r_sample;
    logic                  r_done;
    logic                  r_busy;
    logic                  w_sample_nxt;
    logic                  w_done_nxt;
    logic                  w_busy_nxt;
    logic                  w_col_wrap;
    logic                  w_row_wrap;
    logic                  w_last;
    logic                  w_settled;
    logic [Width-1:0]      w_row;
    logic [Width-1:0]      w_col;

    // The address advances on the edge that ends the sample_o strobe, so the
    // strobe reports the pixel that settled and the next pixel gets a full
    // settle window. Abort returns the address to (0,0).
    counter_wrap #(.Width(Width), .Max(Cols)) u_col (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (abort_i),
        .en_i    (r_sample),
        .count_o (w_col),
        .wrap_o  (w_col_wrap)
    );

    counter_wrap #(.Width(Width), .Max(Rows)) u_row (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (abort_i),
        .en_i    (w_col_wrap),
        .count_o (w_row),
        .wrap_o  (w_row_wrap)
    );

    assign w_last    = (w_row == Width'(Rows - 1)) && (w_col == Width'(Cols - 1));
    assign w_settled = (r_dwell_cnt == r_dwell_q - DwellWidth'(1));

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_state_nxt = r_state;
        if (abort_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (start_i) w_state_nxt = ST_SETTLE;
                ST_SETTLE: if (w_settled) w_state_nxt = ST_SAMPLE;
                ST_SAMPLE: w_state_nxt = (w_last && !cont_i) ? ST_IDLE : ST_SETTLE;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output logic feeding the output registers
    always_comb begin
        w_sample_nxt = (r_state == ST_SAMPLE) && !abort_i;
        w_done_nxt   = w_sample_nxt && w_last;
        w_busy_nxt   = (r_state != ST_IDLE) && !abort_i;
    end

    // Dwell counter and latched frame parameters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dwell_q   <= DwellWidth'(1);
            r_cont_q    <= 1'b0;
            r_dwell_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (start_i && !abort_i) begin
                r_dwell_q   <= (dwell_i == '0) ? DwellWidth'(1) : dwell_i;
                r_cont_q    <= cont_i;
                r_dwell_cnt <= '0;
            end
        end else if (r_state == ST_SETTLE) begin
            r_dwell_cnt <= r_dwell_cnt + DwellWidth'(1);
        end else begin
            r_dwell_cnt <= '0;
            if (w_last && !abort_i) begin
                r_cont_q <= cont_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sample <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_sample <= w_sample_nxt;
            r_done   <= w_done_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign row_o        = w_row;
    assign col_o        = w_col;
    assign sample_o     = r_sample;
    assign frame_done_o = r_done;
    assign busy_o       = r_busy;
    assign dbg_o        = '{state: r_state, cont: r_cont_q};

endmodule
